mem_port_arbiter: RTL and testbench

Sequencing controller that shares one single-ported unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline CPU. It accepts level-held requests from both stages and runs one memory transaction at a time over a req/ack handshake. Conflicts between the two stages resolve round-robin. It drives a pipeline-wide `stall_o` that freezes PC and all stage registers until each pending access has completed.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// One transaction at a time over req/ack; conflicts resolve round-robin.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; arbitrate pending requests
// IFETCH  | fetch request on the memory bus, waiting for ack
// DACCESS | load/store request on the memory bus, waiting for ack
// RESP    | one-cycle ready pulse to the granted port
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ready_o,
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, IFETCH, DACCESS, RESP} state_t;

  state_t state_q, state_d;
  logic   last_grant_q;  // 1 = data port was granted last, 0 = fetch
  logic   gnt_data_q;    // port owning the transaction in flight
  logic   dm_pend;
  logic   start_if, start_dm, ack_hit;

  assign dm_pend = dm_read_i | dm_write_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, grant decision and ack acceptance
  always_comb begin
    state_d  = state_q;
    start_if = 1'b0;
    start_dm = 1'b0;
    ack_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        // data wins unless fetch is also pending and data went last
        if (dm_pend && (!if_req_i || !last_grant_q)) begin
          start_dm = 1'b1;
          state_d  = DACCESS;
        end else if (if_req_i) begin
          start_if = 1'b1;
          state_d  = IFETCH;
        end
      end
      IFETCH, DACCESS: begin
        if (mem_ack_i) begin
          ack_hit = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory bus, result capture and ready pulses
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      if_data_o    <= '0;
      dm_rdata_o   <= '0;
      if_ready_o   <= 1'b0;
      dm_ready_o   <= 1'b0;
      last_grant_q <= 1'b0;
      gnt_data_q   <= 1'b0;
    end else begin
      if_ready_o <= ack_hit & ~gnt_data_q;
      dm_ready_o <= ack_hit & gnt_data_q;
      if (start_dm) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= dm_write_i;  // read+write together counts as a write
        mem_addr_o  <= dm_addr_i;
        mem_wdata_o <= dm_wdata_i;
        gnt_data_q  <= 1'b1;
      end else if (start_if) begin
        mem_req_o  <= 1'b1;
        mem_we_o   <= 1'b0;
        mem_addr_o <= if_addr_i;
        gnt_data_q <= 1'b0;
      end else if (ack_hit) begin
        mem_req_o    <= 1'b0;
        last_grant_q <= gnt_data_q;
        if (!gnt_data_q)    if_data_o  <= mem_rdata_i;
        else if (!mem_we_o) dm_rdata_o <= mem_rdata_i;
      end
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign stall_o = (if_req_i & ~if_ready_o) | (dm_pend & ~dm_ready_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven just after the rising
// edge, outputs sampled on the falling edge.
module tb_mem_port_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        dm_read_i;
  logic        dm_write_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .if_ready_o(if_ready_o),
    .dm_read_i(dm_read_i), .dm_write_i(dm_write_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
    dm_read_i = 1'b0; dm_write_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    nxt(); nxt();
    smp();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_if_data", if_data_o, 0);
    chk("rst_dm_rdata", dm_rdata_o, 0);
    chk("rst_readies", {if_ready_o, dm_ready_o}, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_stall", stall_o, 0);
    nxt(); rst_n_i = 1'b1;

    // fetch alone, ack two cycles after mem_req rises
    nxt(); if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
    smp(); chk("f1_c0_req", mem_req_o, 0); chk("f1_c0_stall", stall_o, 1);
    nxt();
    smp(); chk("f1_c1_req", mem_req_o, 1); chk("f1_c1_we", mem_we_o, 0);
    chk("f1_c1_addr", mem_addr_o, 32'h10); chk("f1_c1_busy", busy_o, 1);
    nxt();
    smp(); chk("f1_c2_req", mem_req_o, 1); chk("f1_c2_rdy", if_ready_o, 0);
    nxt(); mem_ack_i = 1'b1; mem_rdata_i = 32'h8C22_0004;
    smp(); chk("f1_c3_req", mem_req_o, 1); chk("f1_c3_we", mem_we_o, 0);
    nxt(); mem_ack_i = 1'b0;
    smp(); chk("f1_c4_rdy", if_ready_o, 1); chk("f1_c4_data", if_data_o, 32'h8C22_0004);
    chk("f1_c4_req", mem_req_o, 0); chk("f1_c4_dmrdy", dm_ready_o, 0);
    chk("f1_c4_stall", stall_o, 0);
    nxt(); if_req_i = 1'b0;
    smp(); chk("f1_c5_rdy", if_ready_o, 0); chk("f1_c5_stall", stall_o, 0);
    chk("f1_c5_busy", busy_o, 0);

    // conflict: data first, then a second conflict goes to fetch
    nxt(); dm_read_i = 1'b1; dm_addr_i = 32'h40; if_req_i = 1'b1; if_addr_i = 32'h14;
    smp(); chk("cf_c0_stall", stall_o, 1); chk("cf_c0_busy", busy_o, 0);
    nxt(); mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    smp(); chk("cf_c1_req", mem_req_o, 1); chk("cf_c1_addr_data_first", mem_addr_o, 32'h40);
    chk("cf_c1_we", mem_we_o, 0);
    nxt(); mem_ack_i = 1'b0;
    smp(); chk("cf_c2_dmrdy", dm_ready_o, 1); chk("cf_c2_rdata", dm_rdata_o, 32'h1111_2222);
    chk("cf_c2_ifrdy", if_ready_o, 0); chk("cf_c2_stall", stall_o, 1);
    nxt(); dm_addr_i = 32'h44;
    smp(); chk("cf_c3_idle", busy_o, 0); chk("cf_c3_req", mem_req_o, 0);
    chk("cf_c3_stall", stall_o, 1); chk("cf_c3_dmrdy", dm_ready_o, 0);
    nxt(); mem_ack_i = 1'b1; mem_rdata_i = 32'h3333_4444;
    smp(); chk("cf_c4_addr_fetch_second", mem_addr_o, 32'h14); chk("cf_c4_req", mem_req_o, 1);
    nxt(); mem_ack_i = 1'b0;
    smp(); chk("cf_c5_ifrdy", if_ready_o, 1); chk("cf_c5_ifdata", if_data_o, 32'h3333_4444);
    chk("cf_c5_dmrdy", dm_ready_o, 0); chk("cf_c5_stall", stall_o, 1);
    nxt(); if_req_i = 1'b0;
    smp(); chk("cf_c6_idle", busy_o, 0); chk("cf_c6_req", mem_req_o, 0);
    nxt(); mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_6666;
    smp(); chk("cf_c7_addr", mem_addr_o, 32'h44);
    nxt(); mem_ack_i = 1'b0;
    smp(); chk("cf_c8_dmrdy", dm_ready_o, 1); chk("cf_c8_rdata", dm_rdata_o, 32'h5555_6666);
    chk("cf_c8_stall", stall_o, 0);
    nxt(); dm_read_i = 1'b0;
    smp(); chk("cf_c9_idle", busy_o, 0);

    // store: rdata untouched
    nxt(); dm_write_i = 1'b1; dm_addr_i = 32'h20; dm_wdata_i = 32'hDEAD_BEEF;
    smp(); chk("st_c0_stall", stall_o, 1);
    nxt();
    smp(); chk("st_c1_req", mem_req_o, 1); chk("st_c1_we", mem_we_o, 1);
    chk("st_c1_wdata", mem_wdata_o, 32'hDEAD_BEEF); chk("st_c1_addr", mem_addr_o, 32'h20);
    nxt(); mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    smp(); chk("st_c2_we", mem_we_o, 1); chk("st_c2_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("st_c2_req", mem_req_o, 1);
    nxt(); mem_ack_i = 1'b0;
    smp(); chk("st_c3_dmrdy", dm_ready_o, 1); chk("st_c3_rdata_kept", dm_rdata_o, 32'h5555_6666);
    chk("st_c3_req", mem_req_o, 0);
    nxt(); dm_write_i = 1'b0;
    smp(); chk("st_c4_dmrdy", dm_ready_o, 0); chk("st_c4_busy", busy_o, 0);

    // zero-wait memory: spurious ack in idle, then a fetch every 3 cycles
    nxt(); mem_ack_i = 1'b1;
    smp(); chk("zw_spur_busy0", busy_o, 0);
    nxt();
    smp(); chk("zw_spur_busy1", busy_o, 0); chk("zw_spur_req", mem_req_o, 0);
    for (int i = 0; i < 9; i++) begin
      nxt();
      if (i % 3 == 0) begin
        if_req_i = 1'b1;
        if_addr_i = 32'h100 + 32'(4 * (i / 3));
        mem_rdata_i = 32'hA0 + 32'(i / 3);
      end
      smp();
      chk($sformatf("zw_rdy_%0d", i), if_ready_o, (i % 3 == 2) ? 32'd1 : 32'd0);
      if (i % 3 == 1) chk($sformatf("zw_addr_%0d", i), mem_addr_o, 32'h100 + 32'(4 * (i / 3)));
      if (i % 3 == 2) chk($sformatf("zw_data_%0d", i), if_data_o, 32'hA0 + 32'(i / 3));
    end
    nxt(); if_req_i = 1'b0; mem_ack_i = 1'b0;
    smp(); chk("zw_end_busy", busy_o, 0);

    // async reset in DACCESS; data must win the first conflict afterwards
    nxt(); dm_read_i = 1'b1; dm_addr_i = 32'h60;
    nxt(); mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_8888;
    smp(); chk("rs_ld_addr", mem_addr_o, 32'h60);
    nxt(); mem_ack_i = 1'b0;
    smp(); chk("rs_ld_rdy", dm_ready_o, 1);
    nxt(); dm_read_i = 1'b0; dm_write_i = 1'b1; dm_addr_i = 32'h64; dm_wdata_i = 32'h12;
    nxt();
    smp(); chk("rs_pre_req", mem_req_o, 1); chk("rs_pre_we", mem_we_o, 1);
    chk("rs_pre_busy", busy_o, 1);
    #1 rst_n_i = 1'b0;
    #1;
    chk("rs_async_req", mem_req_o, 0); chk("rs_async_busy", busy_o, 0);
    chk("rs_async_rdy", {if_ready_o, dm_ready_o}, 0); chk("rs_async_we", mem_we_o, 0);
    chk("rs_async_rdata", dm_rdata_o, 0); chk("rs_async_ifdata", if_data_o, 0);
    dm_write_i = 1'b0; dm_read_i = 1'b1; dm_addr_i = 32'h70;
    if_req_i = 1'b1; if_addr_i = 32'h30;
    nxt(); rst_n_i = 1'b1;
    smp(); chk("rs_rel_busy", busy_o, 0); chk("rs_rel_req", mem_req_o, 0);
    nxt(); mem_ack_i = 1'b1; mem_rdata_i = 32'h9999_AAAA;
    smp(); chk("rs_conf_data_first", mem_addr_o, 32'h70); chk("rs_conf_req", mem_req_o, 1);
    nxt(); mem_ack_i = 1'b0;
    smp(); chk("rs_conf_dmrdy", dm_ready_o, 1); chk("rs_conf_rdata", dm_rdata_o, 32'h9999_AAAA);
    nxt(); dm_read_i = 1'b0; if_req_i = 1'b0;
    smp(); chk("rs_end_busy", busy_o, 0);

    // fetch withdrawn mid-transaction still completes
    nxt(); if_req_i = 1'b1; if_addr_i = 32'h200;
    nxt(); if_req_i = 1'b0;
    smp(); chk("wd_c1_req", mem_req_o, 1); chk("wd_c1_busy", busy_o, 1);
    chk("wd_c1_stall", stall_o, 0);
    nxt(); mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    nxt(); mem_ack_i = 1'b0;
    smp(); chk("wd_c3_rdy", if_ready_o, 1); chk("wd_c3_data", if_data_o, 32'hCAFE_F00D);
    nxt();
    smp(); chk("wd_c4_rdy", if_ready_o, 0); chk("wd_c4_busy", busy_o, 0);
    chk("wd_c4_req", mem_req_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
